// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters for IF-stage fetch prediction.
// Ports: CLK/nRST, lookup_* -> pred_*, upd_* training, clear, lookup_cnt/mispredict_cnt.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int PERF_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              lookup_en,
  input  logic [31:0]       lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              upd_en,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_mispredict,
  input  logic              clear,
  output logic [PERF_W-1:0] lookup_cnt,
  output logic [PERF_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_WT  =
    {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [29:0]        tgt_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q [ENTRIES];

  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;

  // Low PC/target bits are word-offset only.
  logic unused_bits;
  assign unused_bits =
    ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  assign l_idx = lookup_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[31:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[31:IDX_W+2];

  // No bypass: lookups see state as of the last edge.
  always_comb begin
    pred_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    pred_taken  = pred_hit && ctr_q[l_idx][CTR_W-1];
    pred_target = pred_hit ? {tgt_q[l_idx], 2'b00} : 32'h0;
  end

  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= CTR_WNT;
      end
    end else if (clear) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_WNT;
      end
    end else if (upd_en) begin
      if (u_hit) begin
        if (upd_taken) begin
          if (ctr_q[u_idx] != CTR_MAX)
            ctr_q[u_idx] <= ctr_q[u_idx] + CTR_ONE;
          tgt_q[u_idx] <= upd_target[31:2];
        end else if (ctr_q[u_idx] != '0) begin
          ctr_q[u_idx] <= ctr_q[u_idx] - CTR_ONE;
        end
      end else if (upd_taken) begin
        // Allocation evicts whatever aliased here.
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= upd_target[31:2];
        ctr_q[u_idx]   <= CTR_WT;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lookup_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (lookup_en && !(&lookup_cnt))
        lookup_cnt <= lookup_cnt + PERF_ONE;
      if (upd_en && upd_mispredict && !(&mispredict_cnt))
        mispredict_cnt <= mispredict_cnt + PERF_ONE;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor.
// Drives lookup/update/clear sequences and checks predictions and counters.
module tb_branch_predictor;

  localparam int PW = 4;

  logic          CLK;
  logic          nRST;
  logic          lookup_en;
  logic [31:0]   lookup_pc;
  logic          pred_hit;
  logic          pred_taken;
  logic [31:0]   pred_target;
  logic          upd_en;
  logic [31:0]   upd_pc;
  logic          upd_taken;
  logic [31:0]   upd_target;
  logic          upd_mispredict;
  logic          clear;
  logic [PW-1:0] lookup_cnt;
  logic [PW-1:0] mispredict_cnt;

  branch_predictor #(
    .ENTRIES(16),
    .CTR_W(2),
    .PERF_W(PW)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .lookup_en(lookup_en),
    .lookup_pc(lookup_pc),
    .pred_hit(pred_hit),
    .pred_taken(pred_taken),
    .pred_target(pred_target),
    .upd_en(upd_en),
    .upd_pc(upd_pc),
    .upd_taken(upd_taken),
    .upd_target(upd_target),
    .upd_mispredict(upd_mispredict),
    .clear(clear),
    .lookup_cnt(lookup_cnt),
    .mispredict_cnt(mispredict_cnt)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int errors  = 0;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pop_cmp();
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty: no expected entry");
      return;
    end
    e = sb.pop_front();
    assert ({pred_hit, pred_taken, pred_target} ===
            {e.hit, e.taken, e.tgt})
    else begin
      errors++;
      $error("FAIL %s: got hit=%b taken=%b tgt=%h want hit=%b taken=%b tgt=%h",
             e.tag, pred_hit, pred_taken, pred_target,
             e.hit, e.taken, e.tgt);
    end
  endtask

  task automatic look(input string t, input logic [31:0] pc,
                      input logic h, input logic tk,
                      input logic [31:0] tg);
    exp_t e;
    lookup_pc = pc;
    e.tag = t;
    e.hit = h;
    e.taken = tk;
    e.tgt = tg;
    sb.push_back(e);
    #1;
    pop_cmp();
  endtask

  task automatic cnt(input string t, input logic [PW-1:0] obs,
                     input logic [PW-1:0] want);
    vectors++;
    assert (obs === want)
    else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", t, obs, want);
    end
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk,
                     input logic [31:0] tg);
    upd_en = 1'b1;
    upd_pc = pc;
    upd_taken = tk;
    upd_target = tg;
    step();
    upd_en = 1'b0;
  endtask

  initial begin
    nRST = 1'b0;
    lookup_en = 1'b0;
    lookup_pc = '0;
    upd_en = 1'b0;
    upd_pc = '0;
    upd_taken = 1'b0;
    upd_target = '0;
    upd_mispredict = 1'b0;
    clear = 1'b0;
    step();
    step();
    nRST = 1'b1;
    step();

    look("rst_miss", 32'h40, 0, 0, 32'h0);
    cnt("rst_lcnt", lookup_cnt, 4'd0);
    cnt("rst_mcnt", mispredict_cnt, 4'd0);

    upd_en = 1'b1;
    upd_pc = 32'h40;
    upd_taken = 1'b1;
    upd_target = 32'h100;
    look("alloc_same_cyc", 32'h40, 0, 0, 32'h0);
    step();
    upd_en = 1'b0;
    look("alloc_hit", 32'h40, 1, 1, 32'h100);
    look("alloc_low_bits", 32'h43, 1, 1, 32'h100);

    for (int i = 0; i < 5; i++) upd(32'h40, 1, 32'h100);
    look("sat_hi", 32'h40, 1, 1, 32'h100);
    upd(32'h40, 0, 32'h300);
    look("dec_to_2", 32'h40, 1, 1, 32'h100);
    upd(32'h40, 0, 32'h300);
    look("dec_to_1", 32'h40, 1, 0, 32'h100);
    upd(32'h40, 0, 32'h300);
    upd(32'h40, 0, 32'h300);
    upd(32'h40, 1, 32'h104);
    look("floor_0", 32'h40, 1, 0, 32'h104);
    upd(32'h40, 1, 32'h108);
    look("retrain", 32'h40, 1, 1, 32'h108);

    upd(32'h80, 0, 32'h200);
    look("nt_miss", 32'h80, 0, 0, 32'h0);
    look("nt_keep", 32'h40, 1, 1, 32'h108);
    upd(32'h84, 0, 32'h200);
    look("nt_empty", 32'h84, 0, 0, 32'h0);

    upd(32'h80, 1, 32'h200);
    look("alias_old", 32'h40, 0, 0, 32'h0);
    look("alias_new", 32'h80, 1, 1, 32'h200);
    upd(32'h44, 1, 32'h400);
    look("idx1_hit", 32'h44, 1, 1, 32'h400);
    look("idx0_kept", 32'h80, 1, 1, 32'h200);

    clear = 1'b1;
    upd_en = 1'b1;
    upd_pc = 32'h48;
    upd_taken = 1'b1;
    upd_target = 32'h500;
    step();
    clear = 1'b0;
    upd_en = 1'b0;
    look("clr_80", 32'h80, 0, 0, 32'h0);
    look("clr_44", 32'h44, 0, 0, 32'h0);
    look("clr_48", 32'h48, 0, 0, 32'h0);

    cnt("lcnt_idle", lookup_cnt, 4'd0);
    upd_mispredict = 1'b1;
    step();
    for (int i = 0; i < 3; i++) upd(32'hC8, 0, 32'h0);
    upd_mispredict = 1'b0;
    cnt("mcnt_3", mispredict_cnt, 4'd3);

    lookup_en = 1'b1;
    for (int i = 0; i < 10; i++) step();
    cnt("lcnt_10", lookup_cnt, 4'd10);
    for (int i = 0; i < 10; i++) step();
    lookup_en = 1'b0;
    cnt("lcnt_sat", lookup_cnt, 4'd15);

    clear = 1'b1;
    step();
    clear = 1'b0;
    cnt("mcnt_clr", mispredict_cnt, 4'd3);
    cnt("lcnt_clr", lookup_cnt, 4'd15);

    upd(32'h80, 1, 32'h200);
    look("pre_rst", 32'h80, 1, 1, 32'h200);
    upd_en = 1'b1;
    upd_pc = 32'h88;
    upd_taken = 1'b1;
    upd_target = 32'h600;
    upd_mispredict = 1'b1;
    #3;
    nRST = 1'b0;
    look("rst_async", 32'h80, 0, 0, 32'h0);
    cnt("rst_async_l", lookup_cnt, 4'd0);
    cnt("rst_async_m", mispredict_cnt, 4'd0);
    step();
    upd_en = 1'b0;
    upd_mispredict = 1'b0;
    nRST = 1'b1;
    step();
    look("rst_88", 32'h88, 0, 0, 32'h0);
    look("rst_80", 32'h80, 0, 0, 32'h0);
    cnt("rst_m_hold", mispredict_cnt, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch target buffer with 2-bit saturating direction counters, parametrised in depth, counter width and perf-counter width.
- Sits beside the program counter in the IF stage of the 5-stage pipeline. It supplies a same-cycle taken/target prediction for the fetch PC.
- Branch/jump resolution in ID trains it through a single update port. The datapath redirects on mispredict and reports the event here for statistics.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, 2..256.
- CTR_W, 2, width of each saturating direction counter; 2..4.
- PERF_W, 32, width of the saturating lookup and mispredict statistics counters.
- Derived: IDX_W = log2(ENTRIES); TAG_W = 30 - IDX_W.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- nRST  input  1  asynchronous active-low reset.
- lookup_en  input  1  fetch lookup valid this cycle (IF stage, ihit-qualified).
- lookup_pc  input  32  fetch PC; bits [1:0] ignored.
- pred_hit  output  1  valid entry with matching tag.
- pred_taken  output  1  predict taken (pred_hit and counter MSB = 1).
- pred_target  output  32  predicted target; 0 when pred_hit = 0.
- upd_en  input  1  resolved branch/jump from ID, one-cycle pulse.
- upd_pc  input  32  PC of the resolved instruction.
- upd_taken  input  1  actual direction.
- upd_target  input  32  actual target; bits [1:0] ignored.
- upd_mispredict  input  1  datapath redirected for this instruction (qualified by upd_en).
- clear  input  1  synchronous invalidate of all entries.
- lookup_cnt  output  PERF_W  saturating count of lookup_en cycles.
- mispredict_cnt  output  PERF_W  saturating count of upd_en && upd_mispredict.

Behaviour:
- Entry fields: valid, tag[TAG_W], target[29:0] (word address), ctr[CTR_W].
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
- Lookup is purely combinational with zero latency, independent of lookup_en:
  - pred_hit = valid[idx] && tag match.
  - pred_taken = pred_hit && ctr[idx][CTR_W-1].
  - pred_target = pred_hit ? {target[idx], 2'b00} : 0.
- Update on the rising edge when upd_en = 1:
  - Hit and upd_taken = 1: ctr increments, saturating at all-ones; target is overwritten with upd_target[31:2].
  - Hit and upd_taken = 0: ctr decrements, saturating at 0; target unchanged.
  - Miss and upd_taken = 1: allocate. valid = 1, tag written, target written, ctr = weakly taken (MSB 1, rest 0; 2'b10 for CTR_W = 2). Any prior occupant is evicted.
  - Miss and upd_taken = 0: no state change.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update contents (no bypass). The new value is visible the following cycle.
- clear = 1: all valid bits go to 0 on the edge and counters reset to weakly not-taken (0..01). clear has priority over a simultaneous upd_en. Perf counters are not affected.
- Perf counters:
  - lookup_cnt increments on each edge with lookup_en = 1.
  - mispredict_cnt increments on each edge with upd_en && upd_mispredict.
  - Both saturate at 2^PERF_W - 1 and never wrap.
- Reset (asynchronous, any cycle, including mid-update):
  - All valid = 0; all ctr = weakly not-taken.
  - Tags and targets cleared to 0.
  - lookup_cnt = mispredict_cnt = 0.
  - Outputs immediately read pred_hit = 0, pred_taken = 0, pred_target = 0.
- Aliasing: two PCs with the same index and different tags thrash one entry; there is no associativity.

Test Plan:
- Reset: assert nRST = 0 mid-update -> pred_hit = 0, pred_taken = 0, pred_target = 0, both counters 0; lookup at 0x0000_0040 misses.
- Allocate: upd_en with upd_pc = 0x0000_0040, taken, target 0x0000_0100 -> next cycle lookup_pc = 0x0000_0040 gives hit = 1, taken = 1, target = 0x0000_0100. Before that edge, a same-cycle lookup misses.
- Saturation: five taken updates -> ctr = 3. Then two not-taken updates -> ctr = 1 and pred_taken = 0, with target retained and hit = 1. Further not-taken updates hold ctr at 0.
- Not-taken miss: upd_pc = 0x0000_0080, not taken, on an empty entry -> no allocation; lookup still misses.
- Alias eviction (ENTRIES = 16): allocate 0x0000_0040 (→ 0x100), then 0x0000_0080 (same index 0, different tag; → 0x200) -> 0x40 misses; 0x80 hits with target 0x0000_0200.
- Clear vs counters: clear together with upd_en -> all lookups miss next cycle. With PERF_W = 4, 20 lookup_en cycles -> lookup_cnt = 15. Three mispredict pulses -> mispredict_cnt = 3, unaffected by clear.
